// File: rtl/stopwatch_ctrl_pkg.sv
// Shared encodings and helpers for the stopwatch sequencer.
// The BCD incrementer advances an SS.hh count packed as {s1, s0, h1, h0}.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAP  = 2'd2,
    STOP = 2'd3
  } sw_state_t;

  localparam int BTN_START = 0;
  localparam int BTN_LAP   = 1;
  localparam int BTN_CLR   = 2;

  localparam logic [3:0] DISP_EN = 4'hF;
  localparam logic [3:0] DISP_DP = 4'h4;

  // Full carry chain h0 -> h1 -> s0 -> s1 in one step; 99.99 wraps to 00.00.
  function automatic logic [15:0] bcd_inc(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd9) begin
      r[3:0] = c[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (c[7:4] != 4'd9) begin
        r[7:4] = c[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (c[11:8] != 4'd9) begin
          r[11:8] = c[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = (c[15:12] != 4'd9) ? (c[15:12] + 4'd1) : 4'd0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Single-button conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted rising level.
module sw_debounce #(
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_press
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [DEB_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any cycle that agrees with the accepted level restarts the stability window.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DEB_W'(DEB_CYCLES - 1)) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: debounced buttons drive an IDLE/RUN/LAP/STOP machine
// that counts SS.hh in BCD and produces the 24-bit LED display word.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 500000,
  parameter int DEB_CYCLES = 500000,
  parameter int DEB_W      = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  BTN,
  output logic [23:0] DISP,
  output logic        RUNNING,
  output logic        LAP_HOLD
);

  localparam int              PRE_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  sw_state_t         r_state;
  logic [15:0]       r_cnt;
  logic [15:0]       r_hold;
  logic [PRE_W-1:0]  r_presc;
  logic [23:0]       r_disp;
  logic              r_running;
  logic              r_lap_hold;

  logic [2:0]        w_press;
  logic              w_counting;
  logic              w_tick;
  logic [15:0]       w_cnt_inc;

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_start (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_btn   (BTN[BTN_START]),
    .o_press (w_press[BTN_START])
  );

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_lap (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_btn   (BTN[BTN_LAP]),
    .o_press (w_press[BTN_LAP])
  );

  sw_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_clr (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_btn   (BTN[BTN_CLR]),
    .o_press (w_press[BTN_CLR])
  );

  assign w_counting = (r_state == RUN) || (r_state == LAP);
  assign w_tick     = w_counting && (r_presc == PRE_MAX);
  assign w_cnt_inc  = bcd_inc(r_cnt);

  // Later assignments in this block override earlier ones: clear beats the
  // tick increment, while a RUN->STOP or LAP capture leaves the tick in place.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_hold     <= '0;
      r_presc    <= '0;
      r_disp     <= {DISP_EN, DISP_DP, 16'h0000};
      r_running  <= 1'b0;
      r_lap_hold <= 1'b0;
    end else begin
      if (w_counting) begin
        r_presc <= w_tick ? '0 : (r_presc + 1'b1);
      end
      if (w_tick) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_press[BTN_CLR]) begin
        r_state <= IDLE;
        r_cnt   <= '0;
        r_hold  <= '0;
        r_presc <= '0;
      end else if (w_press[BTN_START]) begin
        case (r_state)
          IDLE: begin
            r_state <= RUN;
            r_presc <= '0;
          end
          RUN:     r_state <= STOP;
          LAP:     r_state <= STOP;
          STOP:    r_state <= RUN;
          default: r_state <= IDLE;
        endcase
      end else if (w_press[BTN_LAP]) begin
        case (r_state)
          RUN: begin
            r_state <= LAP;
            r_hold  <= r_cnt;
          end
          LAP:  r_state <= RUN;
          STOP: begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
          default: ;
        endcase
      end

      // Outputs follow the previous cycle's state and count.
      r_disp     <= {DISP_EN, DISP_DP, (r_state == LAP) ? r_hold : r_cnt};
      r_running  <= w_counting;
      r_lap_hold <= (r_state == LAP);
    end
  end

  assign DISP     = r_disp;
  assign RUNNING  = r_running;
  assign LAP_HOLD = r_lap_hold;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: expected display words are queued as
// stimulus is applied and popped whenever the display word changes.
module tb_stopwatch_ctrl;

  localparam int TICK_DIV   = 10;
  localparam int DEB_CYCLES = 4;
  localparam int DEB_W      = 3;

  logic        CLK;
  logic        RST;
  logic [2:0]  BTN;
  logic [23:0] DISP;
  logic        RUNNING;
  logic        LAP_HOLD;

  stopwatch_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DEB_CYCLES (DEB_CYCLES),
    .DEB_W      (DEB_W)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN      (BTN),
    .DISP     (DISP),
    .RUNNING  (RUNNING),
    .LAP_HOLD (LAP_HOLD)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int          errors    = 0;
  int          checks    = 0;
  int          cyc_n     = 0;
  int          last_cyc  = 0;
  bit          mon_on    = 1'b0;
  bit          chk_gap   = 1'b0;
  bit          gap_armed = 1'b0;
  logic [23:0] last_disp = 24'h0;
  logic [23:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic push_run(input int from, input int to);
    for (int n = from; n <= to; n++) exp_q.push_back({8'hF4, to_bcd(n)});
  endtask

  // One clock; at the falling edge every display change is scored.
  task automatic cyc();
    logic [23:0] e;
    @(negedge CLK);
    cyc_n++;
    if (mon_on && (DISP !== last_disp)) begin
      if (exp_q.size() == 0) begin
        chk("disp_unexpected_change", {8'h0, DISP}, {8'h0, last_disp});
      end else begin
        e = exp_q.pop_front();
        chk("disp_seq", {8'h0, DISP}, {8'h0, e});
      end
      if (chk_gap && gap_armed) chk("tick_gap", cyc_n - last_cyc, TICK_DIV);
      gap_armed = 1'b1;
      last_cyc  = cyc_n;
    end else if (!mon_on) begin
      gap_armed = 1'b0;
    end
    last_disp = DISP;
  endtask

  task automatic press(input logic [2:0] mask, input int n);
    BTN = mask;
    repeat (n) cyc();
    BTN = 3'b000;
  endtask

  task automatic wait_q(input string tag, input int bound);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      cyc();
      n++;
    end
    chk({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int rise;
    RST = 1'b1;
    BTN = 3'b000;
    repeat (3) cyc();
    RST = 1'b0;
    cyc();

    chk("reset_disp", {8'h0, DISP}, 32'h00F40000);
    chk("reset_running", {31'h0, RUNNING}, 0);
    chk("reset_lap_hold", {31'h0, LAP_HOLD}, 0);

    // Idle with no buttons: display must not move.
    mon_on = 1'b1;
    repeat (100) cyc();
    chk("idle_disp", {8'h0, DISP}, 32'h00F40000);
    chk("idle_running", {31'h0, RUNNING}, 0);

    // START held 10 cycles, then count up to 00.99.
    chk_gap = 1'b1;
    push_run(1, 99);
    rise = 0;
    BTN = 3'b001;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (RUNNING && rise == 0) rise = i;
    end
    BTN = 3'b000;
    chk("run_rise_in_window", {31'h0, (rise >= 1 && rise <= DEB_CYCLES + 4)}, 1);
    wait_q("count_to_99", 1200);
    chk("count_running", {31'h0, RUNNING}, 1);

    mon_on = 1'b0;
    press(3'b100, 6);
    repeat (20) cyc();
    chk("clear1_disp", {8'h0, DISP}, 32'h00F40000);
    chk("clear1_running", {31'h0, RUNNING}, 0);

    // Wrap from 99.98 through 00.00.
    force dut.r_cnt = 16'h9998;
    cyc();
    cyc();
    release dut.r_cnt;
    cyc();
    cyc();
    chk("preload_disp", {8'h0, DISP}, 32'h00F49998);
    mon_on  = 1'b1;
    chk_gap = 1'b1;
    exp_q.push_back(24'hF49999);
    exp_q.push_back(24'hF40000);
    exp_q.push_back(24'hF40001);
    press(3'b001, 6);
    wait_q("wrap", 80);

    mon_on = 1'b0;
    press(3'b100, 6);
    repeat (20) cyc();
    chk("clear2_disp", {8'h0, DISP}, 32'h00F40000);

    // Lap hold at 00.12, then release to live count 00.17.
    mon_on  = 1'b1;
    chk_gap = 1'b1;
    push_run(1, 12);
    press(3'b001, 6);
    wait_q("count_to_12", 300);
    chk_gap = 1'b0;
    press(3'b010, 6);
    repeat (44) cyc();
    chk("lap_hold_flag", {31'h0, LAP_HOLD}, 1);
    chk("lap_running", {31'h0, RUNNING}, 1);
    chk("lap_frozen_disp", {8'h0, DISP}, 32'h00F40012);
    push_run(17, 19);
    press(3'b010, 6);
    wait_q("lap_release", 100);
    chk("lap_release_flag", {31'h0, LAP_HOLD}, 0);

    // A 2-cycle START bounce must not stop the count.
    chk_gap = 1'b1;
    push_run(20, 22);
    press(3'b001, 2);
    wait_q("bounce_ignored", 100);
    chk("bounce_running", {31'h0, RUNNING}, 1);

    // START and CLEAR together: CLEAR wins.
    chk_gap = 1'b0;
    exp_q.push_back(24'hF40000);
    press(3'b101, 6);
    wait_q("start_clear_prio", 40);
    repeat (30) cyc();
    chk("prio_running", {31'h0, RUNNING}, 0);
    chk("prio_disp", {8'h0, DISP}, 32'h00F40000);

    // Reset mid-count at 00.45.
    mon_on = 1'b0;
    cyc();
    mon_on  = 1'b1;
    chk_gap = 1'b1;
    push_run(1, 45);
    press(3'b001, 6);
    wait_q("count_to_45", 600);
    chk_gap = 1'b0;
    exp_q.push_back(24'hF40000);
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    chk("rst_mid_disp", {8'h0, DISP}, 32'h00F40000);
    chk("rst_mid_running", {31'h0, RUNNING}, 0);
    repeat (50) cyc();
    chk("rst_hold_disp", {8'h0, DISP}, 32'h00F40000);
    chk("rst_hold_running", {31'h0, RUNNING}, 0);
    chk("final_queue", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
